// File: rtl/divider_pkg.sv
// Shared types and defaults for the 8/4 restoring divider.
// Holds the FSM state type, operand width defaults and iteration-counter sizing.
package divider_pkg;

   localparam int DW_DEF = 8;
   localparam int VW_DEF = 4;

   // Counter must be able to represent DW itself, hence DW+1 codes.
   function automatic int cnt_width(input int dw);
      return $clog2(dw + 1);
   endfunction

   localparam int CNT_W = cnt_width(DW_DEF);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on underflow.
// Purely combinational; no handshake.
module divider_step
   import divider_pkg::*;
#(
   parameter int VW = VW_DEF
) (
   input  logic [VW-1:0] rem_in,
   input  logic          bit_in,
   input  logic [VW-1:0] divisor,
   output logic [VW-1:0] rem_out,
   output logic          q_bit
);

   logic [VW:0] shifted;

   always_comb begin
      shifted = {rem_in, bit_in};
      q_bit   = (shifted >= {1'b0, divisor});
      // A successful subtract always lands below divisor, so the low VW bits suffice.
      rem_out = q_bit ? (shifted[VW-1:0] - divisor) : shifted[VW-1:0];
   end

endmodule

// File: rtl/divider_8x4.sv
// Sequential unsigned divider C/B, one quotient bit per clock MSB first; DW+2 edges start-to-done.
// start is honoured only in IDLE; requests while busy or finishing are dropped, never queued.
module divider_8x4
   import divider_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] C,
   input  logic [VW-1:0] B,
   output logic [DW-1:0] Q,
   output logic [VW-1:0] R,
   output logic          busy,
   output logic          done,
   output logic          dbz
);

   localparam int CW = cnt_width(DW);

   state_t        state;
   state_t        next_state;
   logic          load;
   logic          iterate;
   logic          finish;
   logic          last_iter;

   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [DW-1:0] dvd_q;
   logic [VW-1:0] dvs_q;
   logic [VW-1:0] rem_q;
   logic [CW-1:0] cnt_q;

   logic [VW-1:0] rem_nxt;
   logic          q_bit;

   divider_step #(.VW(VW)) u_step (
      .rem_in  (rem_q),
      .bit_in  (dvd_q[DW-1]),
      .divisor (dvs_q),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   assign last_iter = (cnt_q == CW'(DW - 1));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      iterate    = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               next_state = (B == '0) ? FINISH : BUSY;
            end
         end
         BUSY: begin
            iterate = 1'b1;
            if (last_iter) begin
               next_state = FINISH;
            end
         end
         FINISH: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         Q     <= '0;
         R     <= '0;
         done  <= 1'b0;
         dbz   <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            dvd_q <= C;
            dvs_q <= B;
            rem_q <= '0;
            cnt_q <= '0;
         end
         if (iterate) begin
            dvd_q <= {dvd_q[DW-2:0], q_bit};
            rem_q <= rem_nxt;
            cnt_q <= cnt_q + CW'(1);
         end
         // Zero divisor skips iterations, so dvd_q still holds the original dividend.
         if (finish) begin
            if (dvs_q == '0) begin
               Q   <= '1;
               R   <= dvd_q[VW-1:0];
               dbz <= 1'b1;
            end else begin
               Q   <= dvd_q;
               R   <= rem_q;
               dbz <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_divider_8x4.sv
// Self-checking bench for divider_8x4: directed cases plus random operands against an arithmetic model.
module tb_divider_8x4;

   localparam int DW = 8;
   localparam int VW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] C;
   logic [VW-1:0] B;
   logic [DW-1:0] Q;
   logic [VW-1:0] R;
   logic          busy;
   logic          done;
   logic          dbz;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   divider_8x4 #(.DW(DW), .VW(VW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .C     (C),
      .B     (B),
      .Q     (Q),
      .R     (R),
      .busy  (busy),
      .done  (done),
      .dbz   (dbz)
   );

   // Directed table: C, B, expected Q, R, dbz and edges from accept to done.
   logic [7:0] vc  [7] = '{8'd36, 8'd7,  8'd255, 8'd255, 8'd254, 8'd100, 8'd100};
   logic [3:0] vb  [7] = '{4'd3,  4'd15, 4'd1,   4'd15,  4'd15,  4'd0,   4'd7};
   logic [7:0] vq  [7] = '{8'd12, 8'd0,  8'd255, 8'd17,  8'd16,  8'hFF,  8'd14};
   logic [3:0] vr  [7] = '{4'd0,  4'd7,  4'd0,   4'd0,   4'd14,  4'd4,   4'd2};
   logic       vz  [7] = '{1'b0,  1'b0,  1'b0,   1'b0,   1'b0,   1'b1,   1'b0};
   int         vl  [7] = '{9,     9,     9,      9,      9,      1,      9};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] model(input logic [7:0] c, input logic [3:0] b);
      int ci;
      int bi;
      ci = int'(c);
      bi = int'(b);
      if (bi == 0) return {8'hFF, c[3:0], 1'b1};
      return {8'(ci / bi), 4'(ci % bi), 1'b0};
   endfunction

   // Waits for done after the accepting edge; reports what was seen, checks nothing itself.
   task automatic observe(output int lat, output bit busy_ok, output bit hold_ok,
                          output logic [12:0] res, output int pulses);
      logic [12:0] prev;
      prev    = {Q, R, dbz};
      lat     = 0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      res     = '0;
      pulses  = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done === 1'b1) begin
            lat    = k;
            pulses = 1;
            res    = {Q, R, dbz};
            if (busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         if ({Q, R, dbz} !== prev) hold_ok = 1'b0;
      end
      if (lat != 0) begin
         tick();
         if (done === 1'b1) pulses++;
      end
   endtask

   task automatic run_op(input logic [7:0] c, input logic [3:0] b, output int lat,
                         output bit busy_ok, output bit hold_ok, output logic [12:0] res,
                         output int pulses);
      C     = c;
      B     = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      C     = 8'($urandom);
      B     = 4'($urandom);
      observe(lat, busy_ok, hold_ok, res, pulses);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      C     = '0;
      B     = '0;
      #3;
      n_checks++;
      if ({Q, R} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_qr: got Q=%h R=%h expected 00/0", Q, R);
      end
      n_checks++;
      if ({busy, done, dbz} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got busy/done/dbz=%b expected 000", {busy, done, dbz});
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int lat; bit bok; bit hok; logic [12:0] res; int p;
      run_op(8'd110, 4'd11, lat, bok, hok, res, p);
      n_checks++;
      if (res !== {8'd10, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_result: got %h expected %h", res, {8'd10, 4'd0, 1'b0});
      end
      n_checks++;
      if (lat !== 9) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d expected 9", lat);
      end
      n_checks++;
      if ({bok, hok} !== 2'b11 || p !== 1) begin
         n_fail++;
         $display("FAIL basic_busy_hold_pulse: got busy_ok=%b hold_ok=%b pulses=%0d expected 1 1 1",
                  bok, hok, p);
      end
   endtask

   task automatic test_vectors();
      int lat; bit bok; bit hok; logic [12:0] res; int p;
      for (int i = 0; i < 7; i++) begin
         run_op(vc[i], vb[i], lat, bok, hok, res, p);
         n_checks++;
         if (res !== {vq[i], vr[i], vz[i]}) begin
            n_fail++;
            $display("FAIL vec%0d_result: got %h expected %h", i, res, {vq[i], vr[i], vz[i]});
         end
         n_checks++;
         if (lat !== vl[i] || {bok, hok} !== 2'b11 || p !== 1) begin
            n_fail++;
            $display("FAIL vec%0d_timing: got lat=%0d busy_ok=%b hold_ok=%b pulses=%0d expected lat=%0d 1 1 1",
                     i, lat, bok, hok, p, vl[i]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat; int pulses; logic [12:0] res;
      lat    = 0;
      pulses = 0;
      res    = '0;
      C      = 8'd110;
      B      = 4'd11;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 4) begin
            start = 1'b1;
            C     = 8'd9;
            B     = 4'd3;
         end
         tick();
         start = 1'b0;
         if (done === 1'b1) begin
            pulses++;
            if (lat == 0) begin
               lat = k;
               res = {Q, R, dbz};
            end
         end
      end
      n_checks++;
      if (res !== {8'd10, 4'd0, 1'b0} || lat !== 9) begin
         n_fail++;
         $display("FAIL ignore_result: got %h lat=%0d expected %h lat=9", res, lat, {8'd10, 4'd0, 1'b0});
      end
      n_checks++;
      if (pulses !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_pulses: got pulses=%0d busy=%b expected 1 0", pulses, busy);
      end
   endtask

   task automatic test_reset_mid();
      int lat; bit bok; bit hok; logic [12:0] res; int p;
      C     = 8'd200;
      B     = 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #2;
      n_checks++;
      if ({Q, R, busy, done, dbz} !== 15'h0000) begin
         n_fail++;
         $display("FAIL midrst_async: got Q=%h R=%h busy=%b done=%b dbz=%b expected all 0",
                  Q, R, busy, done, dbz);
      end
      tick();
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL midrst_held: got busy=%b done=%b expected 0 0", busy, done);
      end
      rst   = 1'b0;
      C     = 8'd200;
      B     = 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      observe(lat, bok, hok, res, p);
      n_checks++;
      if (res !== {8'd22, 4'd2, 1'b0} || lat !== 9 || p !== 1) begin
         n_fail++;
         $display("FAIL midrst_restart: got %h lat=%0d pulses=%0d expected %h lat=9 pulses=1",
                  res, lat, p, {8'd22, 4'd2, 1'b0});
      end
   endtask

   task automatic test_back_to_back();
      int lat; bit bok; bit hok; logic [12:0] res; int p;
      C     = 8'd36;
      B     = 4'd3;
      start = 1'b1;
      tick();
      C     = 8'd7;
      B     = 4'd15;
      observe(lat, bok, hok, res, p);
      n_checks++;
      if (res !== {8'd12, 4'd0, 1'b0} || lat !== 9 || p !== 1) begin
         n_fail++;
         $display("FAIL b2b_first: got %h lat=%0d pulses=%0d expected %h lat=9 pulses=1",
                  res, lat, p, {8'd12, 4'd0, 1'b0});
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_reaccept: got busy=%b expected 1", busy);
      end
      start = 1'b0;
      observe(lat, bok, hok, res, p);
      n_checks++;
      if (res !== {8'd0, 4'd7, 1'b0} || lat !== 9) begin
         n_fail++;
         $display("FAIL b2b_second: got %h lat=%0d expected %h lat=9", res, lat, {8'd0, 4'd7, 1'b0});
      end
   endtask

   task automatic test_random();
      int lat; bit bok; bit hok; logic [12:0] res; int p;
      logic [7:0] c; logic [3:0] b; logic [12:0] exp; int exp_lat;
      for (int i = 0; i < 400; i++) begin
         c       = 8'($urandom_range(0, 255));
         b       = 4'($urandom_range(0, 15));
         exp     = model(c, b);
         exp_lat = (b == 4'd0) ? 1 : 9;
         run_op(c, b, lat, bok, hok, res, p);
         n_checks++;
         if (res !== exp) begin
            n_fail++;
            $display("FAIL rand%0d_result C=%0d B=%0d: got %h expected %h", i, c, b, res, exp);
         end
         n_checks++;
         if (lat !== exp_lat || {bok, hok} !== 2'b11 || p !== 1) begin
            n_fail++;
            $display("FAIL rand%0d_timing: got lat=%0d busy_ok=%b hold_ok=%b pulses=%0d expected lat=%0d 1 1 1",
                     i, lat, bok, hok, p, exp_lat);
         end
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/divider_8x4.md
DIVIDER_8X4 -- requirements
Module: divider_8x4

Interface
REQ-001 Parameter DW, default 8: dividend and quotient width.
REQ-002 Parameter VW, default 4: divisor and remainder width.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 start  input  1: request a division; honoured only in IDLE.
REQ-006 C  input  DW: dividend (unsigned); the product-side operand.
REQ-007 B  input  VW: divisor (unsigned).
REQ-008 Q  output  DW: quotient, registered.
REQ-009 R  output  VW: remainder, registered.
REQ-010 busy  output  1: high while a division is in progress.
REQ-011 done  output  1: one-cycle pulse marking Q/R/dbz valid.
REQ-012 dbz  output  1: divide-by-zero flag for the last completed operation.

Function
REQ-013 The block SHALL compute unsigned C / B by restoring division, one quotient bit per clock, MSB first.
REQ-014 FSM states SHALL be IDLE, BUSY, FINISH; IDLE->BUSY on start with B!=0; IDLE->FINISH on start with B==0; BUSY->FINISH after exactly DW iterations; FINISH->IDLE unconditionally.
REQ-015 C and B SHALL be latched on the accepting edge; later input changes SHALL not affect the running operation.
REQ-016 Each iteration: partial remainder (VW+1 bits) shifted left with the next dividend bit; if the result >= divisor, subtract and set the quotient bit to 1, else restore and set it to 0.
REQ-017 Latency: start accepted at edge t0; iterations at edges t1..tDW; Q, R, dbz updated and done high for exactly the cycle after edge tDW+1 (FINISH); busy high from t0 until FINISH exits.
REQ-018 For B==0: no iterations; at the FINISH edge Q SHALL be all ones, R SHALL be C[VW-1:0], and dbz SHALL be 1.
REQ-019 For B!=0: dbz SHALL be 0, and C == Q*B + R with R < B.
REQ-020 start while busy or in FINISH SHALL be ignored and not queued.
REQ-021 Q, R, and dbz SHALL hold their last values until the next operation's FINISH edge.
REQ-022 start held high continuously SHALL begin a new operation on the first IDLE edge after FINISH.
REQ-023 Results SHALL be bit-exact for all 2^(DW+VW) operand pairs.

Reset
REQ-024 On rst, asynchronously: state=IDLE; Q=0, R=0, busy=0, done=0, dbz=0; the iteration counter and operand latches SHALL be cleared.
REQ-025 rst asserted mid-operation SHALL abort it; no done pulse SHALL follow, and the first edge after rst deassertion SHALL accept start.

Structure
REQ-026 Package divider_pkg SHALL hold the FSM state type (IDLE/BUSY/FINISH), the DW and VW defaults, and the iteration-count width clog2(DW+1).
REQ-027 A combinational sub-module divider_step SHALL implement one shift/trial-subtract/restore step; the FSM, counter, and registers SHALL reside in divider_8x4.

Verification
REQ-028 C=110, B=11, start pulse -> done in the cycle after edge t9; Q=10, R=0, dbz=0; busy high t0..t9.
REQ-029 C=36, B=3 -> Q=12, R=0; then C=7, B=15 -> Q=0, R=7.
REQ-030 C=255, B=1 -> Q=255, R=0; C=255, B=15 -> Q=17, R=0; C=254, B=15 -> Q=16, R=14.
REQ-031 C=100, B=0 -> done at the edge after t0; Q=8'hFF, R=4, dbz=1; the next operation C=100, B=7 -> Q=14, R=2, dbz=0.
REQ-032 A second start with C=9, B=3 at t4 of a running 110/11 operation -> ignored; the result is 10 r 0 and only one done pulse occurs.
REQ-033 rst at t5 of 200/9 -> all outputs 0, no done; a start on the first edge after release with 200/9 -> Q=22, R=2.
